// File: rtl/sd_spi_master.sv
// SPI mode-0 master byte engine for the SD-card path: CS control ops and
// full-duplex MSB-first byte transfers at a slow (init) or fast (data) SCLK rate.
module sd_spi_master #(
  parameter int unsigned DIV_SLOW = 64,
  parameter int unsigned DIV_FAST = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] op_i,
  input  logic       start_i,
  input  logic       fast_i,
  input  logic [7:0] txd_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] rxd_o,
  output logic       sd_cs_o,
  output logic       sd_mosi_o,
  output logic       sd_sclk_o,
  input  logic       sd_miso_i
);

  localparam int unsigned CW = 8;
  localparam int unsigned BW = 3;
  localparam logic [1:0] OP_NOP        = 2'b00;
  localparam logic [1:0] OP_CS_ASSERT  = 2'b01;
  localparam logic [1:0] OP_CS_DEASSERT = 2'b10;
  localparam logic [1:0] OP_XFER       = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_FIN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          phase_end;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= 8'hff;
      bitcnt_q <= '0;
      div_q    <= CW'(DIV_SLOW);
      cnt_q    <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rxd_q    <= 8'hff;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rxd_q    <= rxd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rxd_d     = rxd_q;
    phase_end = (cnt_q == div_q - CW'(1));

    unique case (state_q)
      // The done cycle (FIN) also accepts a new request so ops can run back-to-back.
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start_i) begin
          unique case (op_i)
            OP_NOP: begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end
            OP_CS_ASSERT: begin
              cs_d    = 1'b0;
              state_d = S_FIN;
              done_d  = 1'b1;
            end
            OP_CS_DEASSERT: begin
              cs_d    = 1'b1;
              state_d = S_FIN;
              done_d  = 1'b1;
            end
            OP_XFER: begin
              shreg_d  = txd_i;
              bitcnt_d = BW'(7);
              div_d    = fast_i ? CW'(DIV_FAST) : CW'(DIV_SLOW);
              cnt_d    = '0;
              mosi_d   = txd_i[7];
              busy_d   = 1'b1;
              state_d  = S_LOW;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_LOW: begin
        cnt_d = cnt_q + CW'(1);
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        cnt_d = cnt_q + CW'(1);
        // MISO is captured on the last high cycle, just before SCLK falls.
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[6:0], sd_miso_i};
          if (bitcnt_q == '0) begin
            rxd_d   = {shreg_q[6:0], sd_miso_i};
            mosi_d  = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            bitcnt_d = bitcnt_q - BW'(1);
            mosi_d   = shreg_q[6];
            state_d  = S_LOW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rxd_o     = rxd_q;
  assign sd_cs_o   = cs_q;
  assign sd_mosi_o = mosi_q;
  assign sd_sclk_o = sclk_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master: CS ops, loopback transfers, busy-start
// rejection, mid-transfer reset, and a small SD-card command responder.
module tb_sd_spi_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic       start = 1'b0;
  logic       fast = 1'b0;
  logic [7:0] txd = 8'h00;
  logic       busy, done, sd_cs, sd_mosi, sd_sclk, sd_miso;
  logic [7:0] rxd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  logic       miso_mode = 1'b0;  // 0: loopback MOSI->MISO, 1: card model
  logic [7:0] card_out = 8'hff;

  assign sd_miso = miso_mode ? (sd_cs ? 1'b1 : card_out[7]) : sd_mosi;

  sd_spi_master #(.DIV_SLOW(64), .DIV_FAST(4)) dut (
    .clk_i(clk), .reset_i(reset_n), .op_i(op), .start_i(start), .fast_i(fast),
    .txd_i(txd), .busy_o(busy), .done_o(done), .rxd_o(rxd), .sd_cs_o(sd_cs),
    .sd_mosi_o(sd_mosi), .sd_sclk_o(sd_sclk), .sd_miso_i(sd_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveform monitor, sampled mid-cycle.
  int         rises = 0, viol = 0, done_cnt = 0, cs_low_cnt = 0;
  int         rise_q[$];
  logic [7:0] mosi_log = 8'h00;
  logic       m_sclk = 1'b0, m_mosi = 1'b1;
  always @(negedge clk) begin
    if (sd_sclk && !m_sclk) begin
      rises++;
      rise_q.push_back(cyc);
      mosi_log = {mosi_log[6:0], sd_mosi};
    end
    if (sd_sclk && m_sclk && (sd_mosi !== m_mosi)) viol++;
    if (done === 1'b1) done_cnt++;
    if (sd_cs === 1'b0) cs_low_cnt++;
    m_sclk = sd_sclk;
    m_mosi = sd_mosi;
  end

  // Minimal SD card: 6-byte commands, one NCR filler byte, then the response.
  logic [7:0] c_rx = 8'hff, c_cmd = 8'h00;
  int         c_bit = 0, c_n = 0;
  logic       c_prev = 1'b0;
  logic [7:0] resp_q[$];
  always @(posedge clk) begin
    if (sd_cs !== 1'b0) begin
      c_bit = 0;
      c_n = 0;
      card_out <= 8'hff;
    end else begin
      if (sd_sclk && !c_prev) c_rx = {c_rx[6:0], sd_mosi};
      if (!sd_sclk && c_prev) begin
        c_bit++;
        if (c_bit == 8) begin
          c_bit = 0;
          if (c_n == 0) begin
            if (c_rx[7:6] == 2'b01) begin
              c_cmd = c_rx;
              c_n = 1;
            end
          end else begin
            c_n++;
            if (c_n == 6) begin
              c_n = 0;
              resp_q.push_back(8'hff);
              if (c_cmd == 8'h40) resp_q.push_back(8'h01);
              else if (c_cmd == 8'h48) begin
                resp_q.push_back(8'h01); resp_q.push_back(8'h00);
                resp_q.push_back(8'h00); resp_q.push_back(8'h01);
                resp_q.push_back(8'hAA);
              end else resp_q.push_back(8'h05);
            end
          end
          if (resp_q.size() > 0) card_out <= resp_q.pop_front();
          else card_out <= 8'hff;
        end else begin
          card_out <= {card_out[6:0], 1'b1};
        end
      end
    end
    c_prev = sd_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic f, input logic [7:0] d);
    op = o; fast = f; txd = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int exp);
    while (done !== 1'b1 && (cyc - c0) < 20000) begin
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, 32'(cyc - c0), 32'(exp));
  endtask

  task automatic xfer_fast(input logic [7:0] b, output logic [7:0] r);
    issue(2'b11, 1'b1, b);
    wait_done("card_xfer", 64);
    r = rxd;
  endtask

  logic [7:0] r;
  logic       got;
  int         rb, db, cb;
  logic [7:0] cmd0_b[6] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
  logic [7:0] cmd8_b[6] = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
  logic [7:0] r7_b[4]   = '{8'h00, 8'h00, 8'h01, 8'hAA};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", sd_cs, 1);
    chk("rst_sclk", sd_sclk, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rxd", rxd, 8'hff);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // CS assert / deassert take effect with done in the first cycle
    rb = rises;
    issue(2'b01, 1'b0, 8'h00);
    chk("csa_cs", sd_cs, 0);
    wait_done("csa", 0);
    @(posedge clk); #1;
    chk("csa_idle_done", done, 0);
    issue(2'b10, 1'b0, 8'h00);
    chk("csd_cs", sd_cs, 1);
    wait_done("csd", 0);
    chk("cs_no_sclk", 32'(rises - rb), 0);

    // Slow loopback transfer of A5
    miso_mode = 1'b0;
    rb = rises;
    issue(2'b11, 1'b0, 8'hA5);
    chk("a5_busy", busy, 1);
    wait_done("a5", 1024);
    chk("a5_busy_done", busy, 0);
    chk("a5_rxd", rxd, 8'hA5);
    chk("a5_rises", 32'(rises - rb), 8);
    chk("a5_mosi", mosi_log, 8'hA5);
    chk("a5_first_rise", 32'(rise_q[rb] - c0), 64);
    chk("a5_span", 32'(rise_q[rb + 7] - rise_q[rb]), 7 * 128);
    @(posedge clk); #1;
    chk("a5_mosi_idle", sd_mosi, 1);

    // start while busy is ignored; back-to-back start in the done cycle is taken
    rb = rises;
    issue(2'b11, 1'b1, 8'h3C);
    repeat (20) @(posedge clk);
    #1;
    op = 2'b11; txd = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_ign", 64);
    chk("busy_ign_rxd", rxd, 8'h3C);
    chk("busy_ign_mosi", mosi_log, 8'h3C);
    chk("busy_ign_rises", 32'(rises - rb), 8);
    issue(2'b11, 1'b1, 8'hC3);
    wait_done("b2b", 64);
    chk("b2b_rxd", rxd, 8'hC3);

    // Reset mid-transfer aborts with no done and rxd back to ff
    issue(2'b01, 1'b0, 8'h00);
    issue(2'b11, 1'b0, 8'h5A);
    repeat (100) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_cs", sd_cs, 0);
    db = done_cnt;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cs", sd_cs, 1);
    chk("mid_rst_sclk", sd_sclk, 0);
    chk("mid_rst_mosi", sd_mosi, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rxd", rxd, 8'hff);
    reset_n = 1'b1;
    repeat (1100) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt - db), 0);

    // Card model: CMD0 then CMD8
    miso_mode = 1'b1;
    issue(2'b01, 1'b1, 8'h00);
    wait_done("card_cs", 0);
    foreach (cmd0_b[i]) xfer_fast(cmd0_b[i], r);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      xfer_fast(8'hff, r);
      if (r !== 8'hff) got = 1'b1;
    end
    chk("cmd0_r1", r, 8'h01);
    foreach (cmd8_b[i]) xfer_fast(cmd8_b[i], r);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      xfer_fast(8'hff, r);
      if (r !== 8'hff) got = 1'b1;
    end
    chk("cmd8_r1", r, 8'h01);
    foreach (r7_b[i]) begin
      xfer_fast(8'hff, r);
      chk("cmd8_r7", r, r7_b[i]);
    end
    issue(2'b10, 1'b1, 8'h00);
    wait_done("card_csd", 0);

    // Init clocks: 10 slow FF transfers with CS high
    rb = rises;
    cb = cs_low_cnt;
    for (int i = 0; i < 10; i++) begin
      issue(2'b11, 1'b0, 8'hff);
      wait_done("init", 1024);
      chk("init_rxd", rxd, 8'hff);
    end
    chk("init_rises", 32'(rises - rb), 80);
    chk("init_cs_high", 32'(cs_low_cnt - cb), 0);
    chk("mode0_mosi_stable", 32'(viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

SPI master byte engine for the RK8E SD-card path. It sits between the RK8E disk controller sequencer and the SD card pins (sdCS, sdMOSI, sdSCLK, sdMISO); in simulation the `sdsim` card model connects directly to those pins. The controller issues one operation at a time: assert CS, deassert CS, or a full-duplex 8-bit transfer. The block generates the SPI mode-0 waveform at a selectable slow (card init) or fast (data) rate.

## Interface
- DIV_SLOW, 64: SCLK half-period in clk cycles when `fast`=0; legal range 4..255.
- DIV_FAST, 4: SCLK half-period in clk cycles when `fast`=1; legal range 4..255. The minimum of 4 covers the card model's 3-cycle MISO update delay.
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-low reset.
- op  in  2  operation code, sampled with `start`: 00 NOP, 01 CS_ASSERT, 10 CS_DEASSERT, 11 XFER.
- start  in  1  single-cycle request strobe.
- fast  in  1  rate select; sampled with `start`.
- txd  in  8  byte to send, MSB first; sampled with `start`.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rxd  out  8  last byte received; valid from the `done` cycle until the next XFER completes.
- sdCS  out  1  card chip select, active low.
- sdMOSI  out  1  serial data to the card.
- sdSCLK  out  1  serial clock; idles low.
- sdMISO  in  1  serial data from the card.

## Operation
- Reset (reset=0 at a clk edge) sets:
  - sdCS=1, sdSCLK=0, sdMOSI=1
  - busy=0, done=0, rxd=8'hff
  - state IDLE, bit counter 0, divider counter 0
- Reset taking effect mid-transfer aborts immediately. No `done` pulse is produced and rxd is not updated.
- States: IDLE, LOW, HIGH, FIN.
- IDLE
  - `start` is accepted only in IDLE. When accepted, op/fast/txd are latched.
  - NOP: go to FIN.
  - CS_ASSERT: sdCS←0, go to FIN.
  - CS_DEASSERT: sdCS←1, go to FIN.
  - XFER: load the shift register with txd, set bitcnt←7, latch the divider (DIV_FAST or DIV_SLOW), go to LOW.
- LOW
  - sdSCLK=0 and sdMOSI=shreg[7] for DIV cycles, then sdSCLK←1 and go to HIGH.
- HIGH
  - sdSCLK=1 for DIV cycles.
  - On the last HIGH cycle, sample sdMISO and form shreg←{shreg[6:0], sdMISO}.
  - Then sdSCLK←0. If bitcnt=0, go to FIN; otherwise bitcnt−1 and go to LOW.
- FIN
  - done=1 for exactly one cycle and busy←0. For XFER, rxd←shreg. Return to IDLE.
- busy is 1 in LOW, HIGH and FIN-entry, and 0 in the `done` cycle.
- XFER does not touch sdCS. Transfers with sdCS=1 are legal and are used for the ≥74 init clocks.
- sdMOSI returns to 1 when not in LOW/HIGH.
- `start` while busy: ignored, with no side effects and no queuing.
- Divider counter is 8 bits; it counts 0..DIV−1 and reloads on each phase change.

## Timing
- Start accepted at edge T0 and XFER:
  - First LOW phase begins at T0+1.
  - Rising SCLK edges occur at T0+1+DIV+2k·DIV, k=0..7.
  - `done` is high in cycle T0+1+16·DIV; with DIV=4 that is T0+65.
- CS_ASSERT / CS_DEASSERT / NOP: sdCS changes at T0+1, and `done` is high at T0+1.
- Back-to-back: the next `start` may be presented in the `done` cycle and is accepted at that edge.
- MOSI changes only while SCLK is low (mode 0). MISO is sampled in the clk cycle immediately before the falling edge.
- All outputs are registered with no combinational path from input to output.

## Test plan
- Reset behaviour: assert reset mid-XFER -> next cycle sdCS=1, sdSCLK=0, sdMOSI=1, busy=0, rxd=8'hff, no `done` pulse.
- CS_ASSERT then CS_DEASSERT -> sdCS goes 0 at T0+1 with `done` at T0+1; then 1 likewise; sdSCLK stays 0 throughout.
- XFER txd=8'hA5, fast=0, sdMISO looped to sdMOSI -> exactly 8 SCLK rising edges with period 128 clk; MOSI bits 1,0,1,0,0,1,0,1; `done` at T0+1025; rxd=8'hA5.
- XFER fast=1 against `sdsim`:
  - CS_ASSERT, then bytes 40 00 00 00 00 95.
  - Then XFER FF repeatedly -> one received byte equals 8'h01 within 8 polls.
  - CMD8 sequence 48 00 00 01 AA 87 -> bytes 01 00 00 01 AA follow.
- `start` pulsed during busy with txd=8'h00 -> ignored; the original byte completes unchanged, and a new `start` in the `done` cycle is accepted with `done` 16·DIV+1 later.
- 10 XFER 8'hFF with sdCS=1, slow rate -> 80 SCLK rising edges, sdCS never low, every rxd=8'hFF.
